// File: rtl/matrix_loader_pkg.sv
// Shared definitions for the matrix loader and its det4 / bus-interface neighbours.
// Holds the default element geometry and the loader FSM state encoding.
package matrix_loader_pkg;

    localparam int ELEM_W_DEF = 8;
    localparam int N_DEF      = 4;
    localparam int MATRIX_W   = N_DEF * N_DEF * ELEM_W_DEF;

    typedef enum logic [1:0] {
        LOAD      = 2'd0,
        FULL      = 2'd1,
        ERR_DRAIN = 2'd2
    } loader_state_t;

endpackage

// File: rtl/matrix_loader.sv
// Collects a row-major stream of signed elements into one packed N x N matrix,
// holds it until the det4 side takes it, and flags framing errors on in_last.
module matrix_loader
    import matrix_loader_pkg::*;
#(
    parameter int ELEM_W = ELEM_W_DEF,
    parameter int N      = N_DEF,
    localparam int NN    = N * N,
    localparam int MW    = NN * ELEM_W,
    localparam int CNT_W = $clog2(NN) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic signed [ELEM_W-1:0] in_data,
    input  logic                     in_last,
    output logic                     in_ready,
    input  logic                     flush,
    output logic [MW-1:0]            matrix,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CNT_W-1:0]         elem_cnt,
    output logic                     frame_err
);

    loader_state_t state_r;
    logic          accept_s;
    logic          last_idx_s;

    // Element handshake and final-slot detection.
    assign accept_s   = in_valid && in_ready;
    assign last_idx_s = (elem_cnt == CNT_W'(NN - 1));

    // Loader FSM; in_ready/out_valid are registered alongside the state so
    // neither has a combinational path from the handshake inputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r   <= LOAD;
            elem_cnt  <= {CNT_W{1'b0}};
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            matrix    <= {MW{1'b0}};
        end else if (flush) begin
            state_r   <= LOAD;
            elem_cnt  <= {CNT_W{1'b0}};
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state_r)
                LOAD: begin
                    if (accept_s) begin
                        if (last_idx_s || !in_last) begin
                            for (int k = 0; k < NN; k++) begin
                                if (elem_cnt == CNT_W'(k)) begin
                                    matrix[MW-1-k*ELEM_W -: ELEM_W] <= in_data;
                                end
                            end
                        end
                        if (last_idx_s && in_last) begin
                            state_r   <= FULL;
                            elem_cnt  <= CNT_W'(NN);
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end else if (last_idx_s) begin
                            // Frame overran its length: drop everything up to the next in_last.
                            state_r   <= ERR_DRAIN;
                            elem_cnt  <= {CNT_W{1'b0}};
                            frame_err <= 1'b1;
                        end else if (in_last) begin
                            elem_cnt  <= {CNT_W{1'b0}};
                            frame_err <= 1'b1;
                        end else begin
                            elem_cnt  <= elem_cnt + CNT_W'(1);
                        end
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        state_r   <= LOAD;
                        elem_cnt  <= {CNT_W{1'b0}};
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                ERR_DRAIN: begin
                    elem_cnt <= {CNT_W{1'b0}};
                    if (accept_s && in_last) begin
                        state_r <= LOAD;
                    end
                end
                default: begin
                    state_r   <= LOAD;
                    elem_cnt  <= {CNT_W{1'b0}};
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_loader.sv
// Directed bench for matrix_loader: stimulus pushes expected frames into a
// scoreboard queue, an independent monitor pops and compares on out_valid.
module tb_matrix_loader;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic signed [7:0]  in_data;
    logic               in_last;
    logic               in_ready;
    logic               flush;
    logic [127:0]       matrix;
    logic               out_valid;
    logic               out_ready;
    logic [4:0]         elem_cnt;
    logic               frame_err;

    int vectors     = 0;
    int miscompares = 0;
    int err_cnt     = 0;
    logic [127:0] exp_q[$];
    logic [127:0] held;
    logic         prev_ov = 1'b0;
    logic         prev_hs = 1'b0;

    matrix_loader dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .flush     (flush),
        .matrix    (matrix),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .elem_cnt  (elem_cnt),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Send one element and return at posedge+1 after it was accepted.
    task automatic send(input logic [7:0] d, input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 50) check("accept_timeout", 128'(in_ready), 128'(1'b1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // Whole frame, MSB byte first; optional random gaps between elements.
    task automatic send_frame(input logic [127:0] m, input logic gaps);
        logic [127:0] v;
        v = m;
        exp_q.push_back(m);
        for (int k = 0; k < 16; k++) begin
            if (gaps) idle(int'($urandom_range(0, 2)));
            send(v[127-k*8 -: 8], k == 15);
        end
    endtask

    // Monitor: scoreboard pop on each new frame, hold checks while presented.
    always @(negedge clk) begin
        if (frame_err === 1'b1) err_cnt++;
        if (prev_hs) check("fire_once", 128'(out_valid), 128'(1'b0));
        if (out_valid === 1'b1) begin
            check("ready_low_when_full", 128'(in_ready), 128'(1'b0));
            check("cnt_full", 128'(elem_cnt), 128'(5'd16));
            if (!prev_ov) begin
                check("sb_nonempty", 128'(exp_q.size() != 0), 128'(1'b1));
                if (exp_q.size() != 0) check("frame_matrix", matrix, exp_q.pop_front());
                held = matrix;
            end else begin
                check("matrix_stable", matrix, held);
            end
        end
        prev_ov = (out_valid === 1'b1);
        prev_hs = (out_valid === 1'b1) && (out_ready === 1'b1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        rst = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
        flush = 1'b0; out_ready = 1'b1;
        idle(3);
        rst = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 128'(in_ready), 128'(1'b1));
        check("rst_out_valid", 128'(out_valid), 128'(1'b0));
        check("rst_elem_cnt", 128'(elem_cnt), 128'(5'd0));
        check("rst_matrix", matrix, 128'h0);
        check("rst_frame_err", 128'(frame_err), 128'(1'b0));
        @(posedge clk); #1;

        // Scenario 1: reference frame, consumer always ready.
        send_frame(128'h02030201_01020201_00040102_03050101, 1'b0);
        @(negedge clk);
        check("s1_out_valid", 128'(out_valid), 128'(1'b1));
        @(negedge clk);
        check("s1_out_valid_drop", 128'(out_valid), 128'(1'b0));
        check("s1_in_ready", 128'(in_ready), 128'(1'b1));
        check("s1_cnt", 128'(elem_cnt), 128'(5'd0));
        @(posedge clk); #1;

        // Scenario 2: consumer stalls for 5 cycles.
        out_ready = 1'b0;
        send_frame(128'h10111213_14151617_18191A1B_1C1D1E1F, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("s2_hold_valid", 128'(out_valid), 128'(1'b1));
            check("s2_hold_matrix", matrix, 128'h10111213_14151617_18191A1B_1C1D1E1F);
        end
        #1 out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("s2_in_ready_after", 128'(in_ready), 128'(1'b1));
        check("s2_out_valid_after", 128'(out_valid), 128'(1'b0));
        @(posedge clk); #1;

        // Scenario 3: in_last on the 7th element, then a good frame.
        e0 = err_cnt;
        for (int k = 0; k < 6; k++) send(8'(k + 8'h30), 1'b0);
        send(8'h36, 1'b1);
        @(negedge clk);
        check("s3_err_pulse", 128'(frame_err), 128'(1'b1));
        check("s3_cnt_zero", 128'(elem_cnt), 128'(5'd0));
        @(negedge clk);
        check("s3_err_one_cycle", 128'(frame_err), 128'(1'b0));
        check("s3_err_count", 128'(err_cnt - e0), 128'(1));
        @(posedge clk); #1;
        send_frame(128'hA1A2A3A4_B1B2B3B4_C1C2C3C4_D1D2D3D4, 1'b0);
        idle(2);

        // Scenario 4: 18 elements, in_last only on the last one.
        e0 = err_cnt;
        for (int k = 0; k < 16; k++) send(8'(k + 8'h50), 1'b0);
        @(negedge clk);
        check("s4_err_pulse", 128'(frame_err), 128'(1'b1));
        check("s4_drain_ready", 128'(in_ready), 128'(1'b1));
        @(posedge clk); #1;
        send(8'h60, 1'b0);
        send(8'h61, 1'b1);
        @(negedge clk);
        check("s4_cnt_zero", 128'(elem_cnt), 128'(5'd0));
        check("s4_err_count", 128'(err_cnt - e0), 128'(1));
        @(posedge clk); #1;
        send(8'h70, 1'b0);
        @(negedge clk);
        check("s4_back_in_load", 128'(elem_cnt), 128'(5'd1));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;

        // Scenario 5: reset mid-frame, then flush while FULL.
        e0 = err_cnt;
        for (int k = 0; k < 9; k++) send(8'(k + 8'h20), 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("s5_rst_cnt", 128'(elem_cnt), 128'(5'd0));
        check("s5_rst_valid", 128'(out_valid), 128'(1'b0));
        check("s5_rst_matrix", matrix, 128'h0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        send_frame(128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0, 1'b0);
        idle(2);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("s5_flush_valid", 128'(out_valid), 128'(1'b0));
        check("s5_flush_cnt", 128'(elem_cnt), 128'(5'd0));
        check("s5_flush_ready", 128'(in_ready), 128'(1'b1));
        check("s5_flush_matrix", matrix, 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0);
        check("s5_no_err", 128'(err_cnt - e0), 128'(0));
        #1 out_ready = 1'b1;
        @(posedge clk); #1;

        // Scenario 6: sign-extreme values with random in_valid gaps.
        send_frame(128'hFF807F01_FE81007E_40C03FBF_55AA0180, 1'b1);
        idle(4);
        check("s6_sign_msb", 128'(matrix[127]), 128'(1'b1));
        check("sb_empty", 128'(exp_q.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
